axis_arb_mux_2to1: RTL and testbench
====================================

Name: axis_arb_mux_2to1

Overview:
Packet-aware 2:1 AXI-stream arbiter with a registered output. It picks one source per packet by round-robin and holds that choice until the beat with last has been accepted. A two-entry output register/skid stage gives full throughput and breaks the combinational ready path. It sits where the unregistered 2:1 stream mux used to sit, and replaces its external sel with internal arbitration plus output pipelining.

Parameters:
WIDTH, 16, data bus width in bits

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
data_0  input  WIDTH  source 0 data
valid_0  input  1  source 0 valid
last_0  input  1  source 0 end-of-packet marker
ready_0  output  1  source 0 ready
data_1  input  WIDTH  source 1 data
valid_1  input  1  source 1 valid
last_1  input  1  source 1 end-of-packet marker
ready_1  output  1  source 1 ready
data  output  WIDTH  output data (registered)
valid  output  1  output valid (registered)
last  output  1  output end-of-packet (registered)
ready  input  1  downstream ready
grant  output  1  index of the source currently owning the output
busy  output  1  high while a packet is locked (state LOCK)

Behaviour:
- Reset (rst=1 at a clock edge):
  - valid=0, data=0, last=0.
  - state=IDLE, grant=0, busy=0.
  - Skid entry empty. Internal prev_grant=1, so source 0 wins the first tie.
  - ready_0 and ready_1 are 0 while rst=1.
  - Reset mid-packet discards the partial packet and any held beats. No beat is emitted after reset.
- States:
  - IDLE: ready_0=ready_1=0.
    - If exactly one valid_x=1, set grant=x and go to LOCK.
    - If both are valid, set grant=~prev_grant and go to LOCK.
    - If neither is valid, stay in IDLE.
  - LOCK: ready_grant = ~skid_full. The non-granted ready is 0.
    - A beat is accepted when valid_grant & ready_grant.
    - Accepting a beat with last=1 sets prev_grant=grant and returns to IDLE on the next cycle.
- Arbitration costs exactly one IDLE cycle between packets. Within a packet, throughput is 1 beat/cycle.
- grant changes only on the IDLE->LOCK transition. It is stable for the whole packet and keeps its value while in IDLE.
- busy = (state==LOCK).
- Output stage: one output register plus one skid register.
  - When valid=0 or ready=1, the output register loads from the skid if the skid is full, otherwise from the accepted beat, otherwise it clears valid.
  - If a beat is accepted while valid=1 and ready=0, the beat goes into the skid.
  - Latency is 1 cycle from input acceptance to valid on the output.
  - Since ready_grant = ~skid_full, at most one beat sits in the skid. No beat is dropped, duplicated or reordered.
- data, valid and last are held stable while valid=1 and ready=0.
- last is carried unmodified. A single-beat packet (last=1 on the first beat) is legal and ends LOCK after one beat.
- Inputs on the non-granted source are ignored and never back-pressured combinationally. Its ready stays 0 until it is granted.
- valid dropping mid-packet on the granted source: stay in LOCK, output valid goes low once the pipeline drains, and there is no timeout.

Test Plan:
1. After reset, source 0 sends A0,A1,A2(last) with ready=1 held → one IDLE cycle, then ready_0=1. The output shows A0,A1,A2 on consecutive cycles, each 1 cycle after acceptance, with last=1 only on A2. grant=0, busy falls the cycle after A2 is accepted.
2. Both sources present 2-beat packets (P0 on source 0, P1 on source 1) simultaneously from reset → P0 fully out, one bubble, then P1 out. Present both again → source 0 wins (alternation 0,1,0).
3. Source 0 streams an 8-beat packet D0..D7 while ready is low for 3 cycles after D2 appears → ready_0 drops no later than 1 cycle after the stall starts. The output holds D2 stable, and D0..D7 appear in order with none lost or duplicated.
4. Source 1 raises valid_1 during the 2nd beat of a locked 4-beat source 0 packet → ready_1=0 until the source 0 last beat is accepted. Source 1 is then granted after one IDLE cycle.
5. Assert rst for 1 cycle during beat 3 of a 6-beat packet while the skid is full → the next cycle shows valid=0, busy=0, grant=0. A fresh tie then grants source 0.
6. Back-to-back single-beat packets with both sources always valid and ready=1 → output alternates source 0, source 1, … with exactly one bubble between beats and last=1 on every beat.

Source files
------------

// File: rtl/axis_arb_mux_2to1.sv
// rtl/axis_arb_mux_2to1.sv - packet-aware round-robin 2:1 stream arbiter
// with a registered output and a one-entry skid buffer.
module axis_arb_mux_2to1 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_0,
  input  logic             valid_0,
  input  logic             last_0,
  output logic             ready_0,
  input  logic [WIDTH-1:0] data_1,
  input  logic             valid_1,
  input  logic             last_1,
  output logic             ready_1,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             last,
  input  logic             ready,
  output logic             grant,
  output logic             busy
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state, state_nxt;
  logic             grant_nxt;
  logic             prev_grant;

  logic             skid_full;
  logic [WIDTH-1:0] skid_data;
  logic             skid_last;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             accept;

  // Upstream ready depends only on registered state, never on downstream ready.
  always_comb begin
    in_data  = grant ? data_1  : data_0;
    in_valid = grant ? valid_1 : valid_0;
    in_last  = grant ? last_1  : last_0;
    in_ready = (state == LOCK) && !skid_full && !rst;
    ready_0  = in_ready && !grant;
    ready_1  = in_ready && grant;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (valid_0 && valid_1) begin
          grant_nxt = ~prev_grant;
          state_nxt = LOCK;
        end else if (valid_0) begin
          grant_nxt = 1'b0;
          state_nxt = LOCK;
        end else if (valid_1) begin
          grant_nxt = 1'b1;
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        if (accept && in_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      prev_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (accept && in_last) begin
        prev_grant <= grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= 1'b0;
      data      <= '0;
      last      <= 1'b0;
      skid_full <= 1'b0;
      skid_data <= '0;
      skid_last <= 1'b0;
    end else if (!valid || ready) begin
      if (skid_full) begin
        valid     <= 1'b1;
        data      <= skid_data;
        last      <= skid_last;
        skid_full <= 1'b0;
      end else if (accept) begin
        valid <= 1'b1;
        data  <= in_data;
        last  <= in_last;
      end else begin
        valid <= 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the beat that was already accepted upstream.
      skid_full <= 1'b1;
      skid_data <= in_data;
      skid_last <= in_last;
    end
  end

  assign busy = (state == LOCK);

endmodule

// File: tb/tb_axis_arb_mux_2to1.sv
// tb/tb_axis_arb_mux_2to1.sv - scoreboard bench for axis_arb_mux_2to1.
module tb_axis_arb_mux_2to1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_0, data_1, data;
  logic        valid_0, valid_1, valid;
  logic        last_0, last_1, last;
  logic        ready_0, ready_1, ready;
  logic        grant, busy;

  axis_arb_mux_2to1 #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .data_0(data_0), .valid_0(valid_0), .last_0(last_0), .ready_0(ready_0),
    .data_1(data_1), .valid_1(valid_1), .last_1(last_1), .ready_1(ready_1),
    .data(data), .valid(valid), .last(last), .ready(ready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [16:0] q0[$];
  logic [16:0] q1[$];
  logic [16:0] exp_q[$];
  int          out_cyc[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        acc0 = 1'b0;
  logic        acc1 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Source drivers: a beat leaves its queue once it was handshaken at the edge.
  always @(negedge clk) begin
    acc0 = valid_0 && ready_0 && !rst;
    acc1 = valid_1 && ready_1 && !rst;
  end

  always @(posedge clk) begin
    #2;
    if (acc0 && q0.size() > 0) void'(q0.pop_front());
    if (acc1 && q1.size() > 0) void'(q1.pop_front());
    acc0 = 1'b0;
    acc1 = 1'b0;
    valid_0 = (q0.size() > 0);
    data_0  = (q0.size() > 0) ? q0[0][15:0] : 16'h0;
    last_0  = (q0.size() > 0) ? q0[0][16]   : 1'b0;
    valid_1 = (q1.size() > 0);
    data_1  = (q1.size() > 0) ? q1[0][15:0] : 16'h0;
    last_1  = (q1.size() > 0) ? q1[0][16]   : 1'b0;
  end

  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_beat unexpected: got last=%0b data=%h, none expected", last, data);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({last, data} !== e) begin
          errors++;
          $display("FAIL out_beat: got last=%0b data=%h, expected last=%0b data=%h",
                   last, data, e[16], e[15:0]);
        end
      end
      out_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_pkt(input int src, input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [16:0] b;
      b = {(i == n - 1), base + 16'(i)};
      if (src == 0) q0.push_back(b);
      else          q1.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    exp_q.delete();
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_drained"}, exp_q.size() + q0.size() + q1.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    rst = 1'b1;
    ready = 1'b1;
    do_reset();
    @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_last", last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);

    // Test 1: single 3-beat packet, ready held high.
    step();
    out_cyc.delete();
    send_pkt(0, 16'hA000, 3);
    @(negedge clk);
    chk("t1_idle_ready0", ready_0, 0);
    chk("t1_idle_busy", busy, 0);
    @(negedge clk);
    chk("t1_lock_ready0", ready_0, 1);
    chk("t1_lock_busy", busy, 1);
    chk("t1_lock_grant", grant, 0);
    chk("t1_lock_valid", valid, 0);
    @(negedge clk);
    chk("t1_latency_valid", valid, 1);
    chk("t1_latency_data", data, 16'hA000);
    wait_drain("t1");
    chk("t1_busy_after", busy, 0);
    chk("t1_gap01", out_cyc[1] - out_cyc[0], 1);
    chk("t1_gap12", out_cyc[2] - out_cyc[1], 1);

    // Test 2: simultaneous 2-beat packets from reset, then again.
    do_reset();
    out_cyc.delete();
    send_pkt(0, 16'hB000, 2);
    send_pkt(1, 16'hC000, 2);
    wait_drain("t2a");
    chk("t2_gap_in_pkt", out_cyc[1] - out_cyc[0], 1);
    chk("t2_bubble", out_cyc[2] - out_cyc[1], 2);
    step();
    send_pkt(0, 16'hB100, 2);
    send_pkt(1, 16'hC100, 2);
    wait_drain("t2b");

    // Test 3: 8-beat packet with a 3-cycle downstream stall after D2 appears.
    step();
    send_pkt(0, 16'hD000, 8);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (valid && data == 16'hD002) found = 1;
    end
    chk("t3_found_d2", found, 1);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", valid, 1);
      chk("t3_hold_data", data, 16'hD002);
      chk("t3_hold_last", last, 0);
      if (i >= 1) chk("t3_ready0_low", ready_0, 0);
    end
    step();
    ready = 1'b1;
    wait_drain("t3");

    // Test 4: source 1 requests during source 0's locked packet.
    step();
    send_pkt(0, 16'hE000, 4);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (valid_0 && data_0 == 16'hE001) found = 1;
    end
    chk("t4_found_beat2", found, 1);
    send_pkt(1, 16'hF000, 2);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (busy && grant == 1'b0) chk("t4_ready1_blocked", ready_1, 0);
      else found = 1;
    end
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_ready1", ready_1, 0);
    @(negedge clk);
    chk("t4_grant1", grant, 1);
    chk("t4_busy1", busy, 1);
    chk("t4_ready1_open", ready_1, 1);
    wait_drain("t4");

    // Test 5: reset mid-packet with the skid full.
    step();
    ready = 1'b0;
    send_pkt(1, 16'h5000, 6);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (busy && grant && valid && !ready_1) found = 1;
    end
    chk("t5_skid_full", found, 1);
    #1;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    exp_q.delete();
    #1;
    chk("t5_rst_ready0", ready_0, 0);
    chk("t5_rst_ready1", ready_1, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_valid", valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_grant", grant, 0);
    chk("t5_data", data, 0);
    #1;
    ready = 1'b1;
    step();
    send_pkt(0, 16'h6000, 1);
    send_pkt(1, 16'h7000, 1);
    @(negedge clk);
    @(negedge clk);
    chk("t5_tie_grant", grant, 0);
    wait_drain("t5");

    // Test 6: back-to-back single-beat packets, both sources always valid.
    step();
    out_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      send_pkt(0, 16'h8000 + 16'(i), 1);
      send_pkt(1, 16'h9000 + 16'(i), 1);
    end
    wait_drain("t6");
    chk("t6_beats", out_cyc.size(), 6);
    for (int i = 1; i < out_cyc.size(); i++) begin
      chk("t6_gap", out_cyc[i] - out_cyc[i-1], 2);
    end

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
